// File: rtl/memory_access_unit_pkg.sv
// Shared types for the memory access unit: op classes, FSM states and the data-bus request bundle.
package memory_access_unit_pkg;

  typedef enum logic [3:0] {
    LS_NONE, LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR
  } ls_op_t;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DRAIN, DONE
  } mau_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } dbus_req_t;

  // Unaligned word ops always address the containing word.
  function automatic logic is_word_op(ls_op_t op);
    return op inside {LWL, LWR, SWL, SWR};
  endfunction

endpackage

// File: rtl/memory_access_unit_mem_align.sv
// Combinational byte-lane steering: store strobes/data, alignment check and load extract/merge.
module memory_access_unit_mem_align
  import memory_access_unit_pkg::*;
(
  input  ls_op_t      op,
  input  logic [1:0]  a,
  input  logic [31:0] rt,
  input  logic [31:0] word,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        is_load,
  output logic        is_store,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    is_load    = op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    is_store   = op inside {SB, SH, SW, SWL, SWR};
    misaligned = ((op inside {LH, LHU, SH}) && a[0]) ||
                 ((op inside {LW, SW}) && (a != 2'b00));
  end

  always_comb begin
    case (a)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = a[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    rdata = word;
    case (op)
      LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
      LBU: rdata = {24'h0, byte_sel};
      LH:  rdata = {{16{half_sel[15]}}, half_sel};
      LHU: rdata = {16'h0, half_sel};
      LWL: begin
        case (a)
          2'd0:    rdata = {word[7:0],  rt[23:0]};
          2'd1:    rdata = {word[15:0], rt[15:0]};
          2'd2:    rdata = {word[23:0], rt[7:0]};
          default: rdata = word;
        endcase
      end
      LWR: begin
        case (a)
          2'd0:    rdata = word;
          2'd1:    rdata = {rt[31:24], word[31:8]};
          2'd2:    rdata = {rt[31:16], word[31:16]};
          default: rdata = {rt[31:8],  word[31:24]};
        endcase
      end
      default: rdata = word;
    endcase
  end

  always_comb begin
    strb  = 4'b0000;
    wdata = 32'h0;
    case (op)
      SB: begin
        case (a)
          2'd0:    strb = 4'b0001;
          2'd1:    strb = 4'b0010;
          2'd2:    strb = 4'b0100;
          default: strb = 4'b1000;
        endcase
        wdata = {4{rt[7:0]}};
      end
      SH: begin
        strb  = a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rt[15:0]}};
      end
      SW: begin
        strb  = 4'b1111;
        wdata = rt;
      end
      SWL: begin
        case (a)
          2'd0:    begin strb = 4'b0001; wdata = {24'h0, rt[31:24]}; end
          2'd1:    begin strb = 4'b0011; wdata = {16'h0, rt[31:16]}; end
          2'd2:    begin strb = 4'b0111; wdata = {8'h0,  rt[31:8]};  end
          default: begin strb = 4'b1111; wdata = rt;                 end
        endcase
      end
      SWR: begin
        case (a)
          2'd0:    begin strb = 4'b1111; wdata = rt;                 end
          2'd1:    begin strb = 4'b1110; wdata = {rt[23:0], 8'h0};   end
          2'd2:    begin strb = 4'b1100; wdata = {rt[15:0], 16'h0};  end
          default: begin strb = 4'b1000; wdata = {rt[7:0],  24'h0};  end
        endcase
      end
      default: begin
        strb  = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage: alignment check, single data-bus transaction per op, load result to writeback.
// state | meaning
// IDLE  | ready for a new op from execute
// REQ   | bus request presented, waiting for req_ready
// WAIT  | request accepted, waiting for read data / write ack
// DRAIN | op flushed after bus accepted it; swallow the response
// DONE  | result presented to writeback until out_ready
module memory_access_unit
  import memory_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  ls_op_t      in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_rt,
  input  logic        in_exc,
  input  logic        flush,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic        dbus_req_write,
  output logic [31:0] dbus_req_addr,
  output logic [3:0]  dbus_req_strb,
  output logic [31:0] dbus_req_data,
  input  logic        dbus_resp_valid,
  input  logic [31:0] dbus_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_adel,
  output logic        out_ades,
  output logic [31:0] out_badvaddr
);

  mau_state_t  state, state_nx;
  ls_op_t      op_q;
  logic [31:0] addr_q, rt_q, out_data_q, badvaddr_q;
  logic        adel_q, ades_q;

  ls_op_t      al_op;
  logic [1:0]  al_a;
  logic [31:0] al_rt, al_wdata, al_rdata;
  logic [3:0]  al_strb;
  logic        al_mis, al_is_load, al_is_store;

  logic        accept, take_bus, fault;
  dbus_req_t   req;

  // The aligner sees the live inputs while idle, the captured op afterwards.
  assign al_op = (state == IDLE) ? in_op           : op_q;
  assign al_a  = (state == IDLE) ? in_addr[1:0]    : addr_q[1:0];
  assign al_rt = (state == IDLE) ? in_rt           : rt_q;

  memory_access_unit_mem_align u_align (
    .op         (al_op),
    .a          (al_a),
    .rt         (al_rt),
    .word       (dbus_resp_data),
    .strb       (al_strb),
    .wdata      (al_wdata),
    .misaligned (al_mis),
    .is_load    (al_is_load),
    .is_store   (al_is_store),
    .rdata      (al_rdata)
  );

  assign accept   = in_valid && in_ready && !flush;
  assign fault    = al_mis && !in_exc;
  assign take_bus = (al_is_load || al_is_store) && !in_exc && !al_mis;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = take_bus ? REQ : DONE;
      REQ: begin
        if (flush)               state_nx = dbus_req_ready ? DRAIN : IDLE;
        else if (dbus_req_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (dbus_resp_valid) state_nx = flush ? IDLE : DONE;
        else if (flush)      state_nx = DRAIN;
      end
      DRAIN: if (dbus_resp_valid) state_nx = IDLE;
      DONE:  if (flush || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= LS_NONE;
      addr_q     <= 32'h0;
      rt_q       <= 32'h0;
      out_data_q <= 32'h0;
      badvaddr_q <= 32'h0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
    end else if (accept) begin
      op_q       <= in_op;
      addr_q     <= in_addr;
      rt_q       <= in_rt;
      out_data_q <= in_addr;
      adel_q     <= fault && al_is_load;
      ades_q     <= fault && al_is_store;
      badvaddr_q <= fault ? in_addr : 32'h0;
    end else if (state == WAIT && dbus_resp_valid && !flush) begin
      out_data_q <= al_is_load ? al_rdata : addr_q;
    end
  end

  assign req.write = al_is_store;
  assign req.addr  = is_word_op(op_q) ? {addr_q[31:2], 2'b00} : addr_q;
  assign req.strb  = al_strb;
  assign req.data  = al_wdata;

  assign dbus_req_valid = (state == REQ);
  assign dbus_req_write = req.write;
  assign dbus_req_addr  = req.addr;
  assign dbus_req_strb  = req.strb;
  assign dbus_req_data  = req.data;

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign out_data     = out_data_q;
  assign out_adel     = adel_q;
  assign out_ades     = ades_q;
  assign out_badvaddr = badvaddr_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench: directed vector table, flush/reset sequences, random ops against a lane-arithmetic model.
module tb_memory_access_unit;
  import memory_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_exc, flush;
  ls_op_t      in_op;
  logic [31:0] in_addr, in_rt;
  logic        in_ready;
  logic        dbus_req_valid, dbus_req_ready, dbus_req_write;
  logic [31:0] dbus_req_addr, dbus_req_data;
  logic [3:0]  dbus_req_strb;
  logic        dbus_resp_valid;
  logic [31:0] dbus_resp_data;
  logic        out_valid, out_ready, out_adel, out_ades;
  logic [31:0] out_data, out_badvaddr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_access_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_rt(in_rt), .in_exc(in_exc), .flush(flush),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_req_write(dbus_req_write), .dbus_req_addr(dbus_req_addr),
    .dbus_req_strb(dbus_req_strb), .dbus_req_data(dbus_req_data),
    .dbus_resp_valid(dbus_resp_valid), .dbus_resp_data(dbus_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_adel(out_adel), .out_ades(out_ades), .out_badvaddr(out_badvaddr)
  );

  typedef struct {
    ls_op_t      op;
    logic [31:0] addr, rt, w;
    logic        exc;
    int          rdly;
    logic        bus;
    logic [31:0] data;
    logic        adel, ades;
    logic [3:0]  strb;
    logic [31:0] wdata, raddr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte-lane arithmetic on shift amounts, not case tables.
  task automatic model(input ls_op_t op, input logic [31:0] a, rt, w, input logic exc,
                       output logic bus, output logic [31:0] data, output logic adel, ades,
                       output logic [3:0] strb, output logic [31:0] wdata, raddr);
    int o, align;
    logic ld, st, mis;
    logic [31:0] b, h;
    o  = int'(a[1:0]);
    ld = op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    st = op inside {SB, SH, SW, SWL, SWR};
    align = (op inside {LH, LHU, SH}) ? 2 : (op inside {LW, SW}) ? 4 : 1;
    mis = (o % align) != 0;
    data = a; adel = 0; ades = 0; strb = 0; wdata = 0; bus = 0;
    raddr = (op inside {LWL, LWR, SWL, SWR}) ? (a & ~32'd3) : a;
    if (exc || !(ld || st)) return;
    if (mis) begin
      adel = ld; ades = st;
      return;
    end
    bus = 1;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (8 * o)) & 32'hFFFF;
    case (op)
      LB:  data = (b >= 128) ? b - 32'd256 : b;
      LBU: data = b;
      LH:  data = (h >= 32768) ? h - 32'd65536 : h;
      LHU: data = h;
      LW:  data = w;
      LWL: data = (w << (8 * (3 - o))) | (rt & ((32'd1 << (8 * (3 - o))) - 32'd1));
      LWR: data = (w >> (8 * o)) | (rt & ~(32'hFFFF_FFFF >> (8 * o)));
      SB:  begin strb = 4'(1 << o);           wdata = (rt & 32'hFF) * 32'h0101_0101; end
      SH:  begin strb = 4'(3 << o);           wdata = (rt & 32'hFFFF) * 32'h0001_0001; end
      SW:  begin strb = 4'hF;                 wdata = rt; end
      SWL: begin strb = 4'((1 << (o + 1)) - 1); wdata = rt >> (8 * (3 - o)); end
      SWR: begin strb = 4'(15 << o);          wdata = rt << (8 * o); end
      default: ;
    endcase
  endtask

  task automatic run_txn(input ls_op_t op, input logic [31:0] a, rt, w, input logic exc,
                         input int rdly, sdly, odly,
                         input logic ebus, input logic [31:0] edata, input logic eadel, eades,
                         input logic [3:0] estrb, input logic [31:0] ewdata, eraddr);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1; in_op = op; in_addr = a; in_rt = rt; in_exc = exc;
    tick();
    in_valid = 0; in_op = LS_NONE; in_addr = ~a; in_rt = ~rt; in_exc = 0;
    if (ebus) begin
      for (int i = 0; i <= rdly; i++) begin
        chk("req_valid", 32'(dbus_req_valid), 32'd1);
        chk("req_addr", dbus_req_addr, eraddr);
        chk("req_strb", 32'(dbus_req_strb), 32'(estrb));
        chk("req_write", 32'(dbus_req_write), 32'(estrb != 4'h0));
        if (estrb != 4'h0) chk("req_data", dbus_req_data, ewdata);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        if (i == rdly) dbus_req_ready = 1;
        tick();
      end
      dbus_req_ready = 0;
      for (int i = 0; i < sdly; i++) begin
        chk("req_dropped", 32'(dbus_req_valid), 32'd0);
        chk("wait_out_valid", 32'(out_valid), 32'd0);
        tick();
      end
      dbus_resp_valid = 1; dbus_resp_data = w;
      tick();
      dbus_resp_valid = 0; dbus_resp_data = $urandom;
    end else begin
      chk("no_req", 32'(dbus_req_valid), 32'd0);
    end
    for (int i = 0; i <= odly; i++) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      if (!(eadel || eades) && !(ebus && estrb != 4'h0)) chk("out_data", out_data, edata);
      chk("out_adel", 32'(out_adel), 32'(eadel));
      chk("out_ades", 32'(out_ades), 32'(eades));
      if (eadel || eades) chk("badvaddr", out_badvaddr, a);
      chk("done_in_ready", 32'(in_ready), 32'd0);
      chk("done_no_req", 32'(dbus_req_valid), 32'd0);
      if (i == odly) out_ready = 1;
      tick();
    end
    out_ready = 0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic        mb, madel, mades;
    logic [31:0] md, mw, mra, a, rt, w;
    logic [3:0]  ms;
    ls_op_t      op;
    logic        exc;

    //            op       addr          rt            w            exc rdly bus data          adel ades strb   wdata         raddr
    vecs[0]  = '{LW,  32'h8000_0004, 32'h0,        32'hDEADBEEF, 0, 2, 1, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0,        32'h8000_0004};
    vecs[1]  = '{LB,  32'h1000_0001, 32'h0,        32'h1234_80FF, 0, 0, 1, 32'hFFFF_FF80, 0, 0, 4'h0, 32'h0,        32'h1000_0001};
    vecs[2]  = '{LBU, 32'h1000_0001, 32'h0,        32'h1234_80FF, 0, 0, 1, 32'h0000_0080, 0, 0, 4'h0, 32'h0,        32'h1000_0001};
    vecs[3]  = '{LH,  32'h1000_0002, 32'h0,        32'h1234_80FF, 0, 1, 1, 32'h0000_1234, 0, 0, 4'h0, 32'h0,        32'h1000_0002};
    vecs[4]  = '{LWL, 32'h2000_0001, 32'hAABBCCDD, 32'h1122_3344, 0, 0, 1, 32'h3344_CCDD, 0, 0, 4'h0, 32'h0,        32'h2000_0000};
    vecs[5]  = '{LWR, 32'h2000_0002, 32'hAABBCCDD, 32'h1122_3344, 0, 0, 1, 32'hAABB_1122, 0, 0, 4'h0, 32'h0,        32'h2000_0000};
    vecs[6]  = '{SWL, 32'h3000_0002, 32'hAABBCCDD, 32'h0,         0, 0, 1, 32'h0,         0, 0, 4'h7, 32'h00AA_BBCC, 32'h3000_0000};
    vecs[7]  = '{SH,  32'h4000_0003, 32'h1234_5678, 32'h0,        0, 0, 0, 32'h0,         0, 1, 4'h0, 32'h0,        32'h4000_0003};
    vecs[8]  = '{LW,  32'h4000_0002, 32'h0,        32'h0,         0, 0, 0, 32'h0,         1, 0, 4'h0, 32'h0,        32'h4000_0002};
    vecs[9]  = '{LS_NONE, 32'h1234_5678, 32'h0,    32'h0,         0, 0, 0, 32'h1234_5678, 0, 0, 4'h0, 32'h0,        32'h1234_5678};
    vecs[10] = '{LW,  32'h4000_0002, 32'h0,        32'h0,         1, 0, 0, 32'h4000_0002, 0, 0, 4'h0, 32'h0,        32'h4000_0002};
    vecs[11] = '{SB,  32'h5000_0003, 32'h0000_00A5, 32'h0,        0, 0, 1, 32'h0,         0, 0, 4'h8, 32'hA5A5_A5A5, 32'h5000_0003};
    vecs[12] = '{LHU, 32'h1000_0002, 32'h0,        32'h8765_0000, 0, 0, 1, 32'h0000_8765, 0, 0, 4'h0, 32'h0,        32'h1000_0002};
    vecs[13] = '{SWR, 32'h6000_0001, 32'hAABBCCDD, 32'h0,         0, 0, 1, 32'h0,         0, 0, 4'hE, 32'hBBCC_DD00, 32'h6000_0000};

    reset = 1; in_valid = 0; in_op = LS_NONE; in_addr = 0; in_rt = 0; in_exc = 0; flush = 0;
    dbus_req_ready = 0; dbus_resp_valid = 0; dbus_resp_data = 0; out_ready = 0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req_valid", 32'(dbus_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_badvaddr", out_badvaddr, 32'h0);
    chk("rst_adel_ades", {30'h0, out_adel, out_ades}, 32'h0);
    reset = 0;
    tick();

    foreach (vecs[i])
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].w, vecs[i].exc, vecs[i].rdly, 0, 0,
              vecs[i].bus, vecs[i].data, vecs[i].adel, vecs[i].ades,
              vecs[i].strb, vecs[i].wdata, vecs[i].raddr);

    // pass-through with writeback stalled four cycles
    run_txn(LS_NONE, 32'hCAFE_0001, 32'h0, 32'h0, 0, 0, 0, 4, 0, 32'hCAFE_0001, 0, 0, 4'h0, 32'h0, 32'h0);

    // flush in WAIT, response three cycles later is swallowed
    in_valid = 1; in_op = LW; in_addr = 32'h7000_0000; tick(); in_valid = 0;
    dbus_req_ready = 1; tick(); dbus_req_ready = 0;
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_no_req", 32'(dbus_req_valid), 32'd0);
      tick();
    end
    dbus_resp_valid = 1; dbus_resp_data = 32'h5555_AAAA; tick(); dbus_resp_valid = 0;
    chk("drain_done_out_valid", 32'(out_valid), 32'd0);
    chk("drain_done_in_ready", 32'(in_ready), 32'd1);

    // flush in REQ before acceptance drops the request
    in_valid = 1; in_op = SW; in_addr = 32'h7000_0010; tick(); in_valid = 0;
    chk("req_before_flush", 32'(dbus_req_valid), 32'd1);
    flush = 1; tick(); flush = 0;
    chk("req_flush_no_req", 32'(dbus_req_valid), 32'd0);
    chk("req_flush_in_ready", 32'(in_ready), 32'd1);

    // flush in DONE drops out_valid
    in_valid = 1; in_op = LS_NONE; in_addr = 32'h1; tick(); in_valid = 0;
    flush = 1; tick(); flush = 0;
    chk("done_flush_out_valid", 32'(out_valid), 32'd0);
    chk("done_flush_in_ready", 32'(in_ready), 32'd1);

    // flush beats in_valid: nothing accepted
    in_valid = 1; in_op = LW; in_addr = 32'h2; flush = 1; tick(); in_valid = 0; flush = 0;
    chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
    chk("flush_idle_out_valid", 32'(out_valid), 32'd0);
    chk("flush_idle_no_req", 32'(dbus_req_valid), 32'd0);

    // response coincident with flush in WAIT returns straight to IDLE
    in_valid = 1; in_op = LW; in_addr = 32'h7000_0020; tick(); in_valid = 0;
    dbus_req_ready = 1; tick(); dbus_req_ready = 0;
    flush = 1; dbus_resp_valid = 1; tick(); flush = 0; dbus_resp_valid = 0;
    chk("wait_flush_resp_in_ready", 32'(in_ready), 32'd1);
    chk("wait_flush_resp_out_valid", 32'(out_valid), 32'd0);

    // reset mid-transaction
    in_valid = 1; in_op = LW; in_addr = 32'h7000_0030; tick(); in_valid = 0;
    reset = 1; tick(); reset = 0;
    chk("midrst_req_valid", 32'(dbus_req_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_data", out_data, 32'h0);

    for (int n = 0; n < 200; n++) begin
      op  = ls_op_t'(4'($urandom_range(0, 12)));
      a   = $urandom; rt = $urandom; w = $urandom;
      exc = ($urandom_range(0, 7) == 0);
      model(op, a, rt, w, exc, mb, md, madel, mades, ms, mw, mra);
      run_txn(op, a, rt, w, exc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              mb, md, madel, mades, ms, mw, mra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
